// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: scoreboard hazard checks, fixed-latency writeback slots,
// non-pipelined divider occupancy, illegal-op trapping and stall accounting.
module fpu_issue_ctrl (
  input  logic        cpu_clock,
  input  logic        cpu_reset_b,
  input  logic        issue_valid,
  input  logic [2:0]  issue_op,
  input  logic [4:0]  issue_fd,
  input  logic [4:0]  issue_fs,
  input  logic [4:0]  issue_ft,
  output logic        issue_ready,
  input  logic        flush,
  output logic        fpu_start,
  output logic [2:0]  fpu_op,
  output logic [4:0]  fpu_fs,
  output logic [4:0]  fpu_ft,
  output logic [4:0]  fpu_fd,
  output logic        wb_en,
  output logic [4:0]  wb_fd,
  output logic        illegal,
  output logic        fpu_idle,
  output logic [15:0] stall_cycles
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;

  logic [31:0] r_busy;
  logic [12:1] r_slot_v;
  logic [4:0]  r_slot_fd [1:12];
  logic [3:0]  r_div_cnt;
  logic        r_illegal;
  logic [15:0] r_stall_cnt;

  logic        w_legal;
  logic        w_uses_ft;
  logic        w_slot_free;
  logic        w_div_free;
  logic        w_hazard_ok;
  logic [3:0]  w_lat;
  logic [3:0]  w_div_dec;
  logic [12:1] w_shift_v;
  logic [12:1] w_slot_v_nxt;
  logic [4:0]  w_slot_fd_nxt [1:12];
  logic [31:0] w_busy_nxt;

  // Hazard evaluation uses the post-shift slot view and post-decrement divider count
  always_comb begin
    w_legal   = (issue_op <= OP_NEG);
    w_uses_ft = !((issue_op == OP_MOV) || (issue_op == OP_NEG));
    case (issue_op)
      OP_ADD, OP_SUB: w_lat = 4'd3;
      OP_MUL:         w_lat = 4'd4;
      OP_DIV:         w_lat = 4'd12;
      default:        w_lat = 4'd1;
    endcase
    w_shift_v   = {1'b0, r_slot_v[12:2]};
    w_slot_free = !w_shift_v[w_lat];
    w_div_dec   = (r_div_cnt != 4'd0) ? (r_div_cnt - 4'd1) : 4'd0;
    w_div_free  = (w_div_dec == 4'd0);
    w_hazard_ok = !r_busy[issue_fs] && (!w_uses_ft || !r_busy[issue_ft]) &&
                  !r_busy[issue_fd] && w_slot_free &&
                  ((issue_op != OP_DIV) || w_div_free);
    issue_ready = !flush && !cpu_reset_b && (!w_legal || w_hazard_ok);
    fpu_start   = issue_valid && issue_ready && w_legal;
  end

  always_comb begin
    for (int k = 1; k < 12; k++) begin
      w_slot_v_nxt[k]  = r_slot_v[k+1];
      w_slot_fd_nxt[k] = r_slot_fd[k+1];
    end
    w_slot_v_nxt[12]  = 1'b0;
    w_slot_fd_nxt[12] = 5'd0;
    w_busy_nxt = r_busy;
    if (r_slot_v[1])
      w_busy_nxt[r_slot_fd[1]] = 1'b0;
    if (fpu_start) begin
      w_slot_v_nxt[w_lat]  = 1'b1;
      w_slot_fd_nxt[w_lat] = issue_fd;
      w_busy_nxt[issue_fd] = 1'b1;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (cpu_reset_b || flush) begin
      r_busy    <= '0;
      r_slot_v  <= '0;
      r_div_cnt <= 4'd0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_slot_v  <= w_slot_v_nxt;
      r_div_cnt <= (fpu_start && (issue_op == OP_DIV)) ? 4'd12 : w_div_dec;
    end
  end

  always_ff @(posedge cpu_clock) begin
    r_slot_fd <= w_slot_fd_nxt;
  end

  always_ff @(posedge cpu_clock) begin
    if (cpu_reset_b) begin
      r_illegal   <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_illegal <= issue_valid && issue_ready && !w_legal;
      if (issue_valid && !issue_ready && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fpu_op       = issue_op;
  assign fpu_fs       = issue_fs;
  assign fpu_ft       = issue_ft;
  assign fpu_fd       = issue_fd;
  assign wb_en        = r_slot_v[1] && !cpu_reset_b;
  assign wb_fd        = r_slot_fd[1];
  assign illegal      = r_illegal;
  assign fpu_idle     = (r_busy == 32'd0) && (r_div_cnt == 4'd0);
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: latency, hazards, slot conflicts, divider,
// flush, illegal ops and mid-operation reset with hand-computed expectations.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic [4:0]  issue_fd, issue_fs, issue_ft;
  logic        issue_ready;
  logic        flush;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic [4:0]  fpu_fs, fpu_ft, fpu_fd;
  logic        wb_en;
  logic [4:0]  wb_fd;
  logic        illegal;
  logic        fpu_idle;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] ADD = 3'd0, MUL = 3'd2, DIV = 3'd3, MOV = 3'd4, BAD = 3'd7;

  fpu_issue_ctrl dut (
    .cpu_clock(clk), .cpu_reset_b(rst), .issue_valid(issue_valid),
    .issue_op(issue_op), .issue_fd(issue_fd), .issue_fs(issue_fs),
    .issue_ft(issue_ft), .issue_ready(issue_ready), .flush(flush),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_fs(fpu_fs), .fpu_ft(fpu_ft),
    .fpu_fd(fpu_fd), .wb_en(wb_en), .wb_fd(wb_fd), .illegal(illegal),
    .fpu_idle(fpu_idle), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive the payload just after the rising edge, return mid-cycle
  task automatic cyc(input logic r, input logic v, input logic [2:0] op,
                     input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft,
                     input logic fl);
    @(posedge clk);
    #1;
    rst = r; issue_valid = v; issue_op = op;
    issue_fd = fd; issue_fs = fs; issue_ft = ft; flush = fl;
    #4;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, ADD, 5'd31, 5'd31, 5'd31, 1'b0);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_op = ADD;
    issue_fd = 5'd0; issue_fs = 5'd0; issue_ft = 5'd0; flush = 1'b0;

    // Reset behaviour
    cyc(1'b1, 1'b1, ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("rst_ready", issue_ready, 0);
    chk("rst_start", fpu_start, 0);
    chk("rst_wb", wb_en, 0);
    cyc(1'b1, 1'b0, ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    idle_cyc();
    chk("post_rst_wb", wb_en, 0);
    chk("post_rst_illegal", illegal, 0);
    chk("post_rst_idle", fpu_idle, 1);
    chk("post_rst_stall", stall_cycles, 0);

    // ADD fd=2: start at T, writeback at T+3 only, idle at T+4
    cyc(1'b0, 1'b1, ADD, 5'd2, 5'd0, 5'd1, 1'b0);
    chk("add_ready", issue_ready, 1);
    chk("add_start", fpu_start, 1);
    chk("add_fpu_fd", fpu_fd, 2);
    chk("add_fpu_op", fpu_op, 0);
    chk("add_fpu_fs", fpu_fs, 0);
    chk("add_fpu_ft", fpu_ft, 1);
    idle_cyc(); chk("add_wb_t1", wb_en, 0); chk("add_busy_t1", fpu_idle, 0);
    idle_cyc(); chk("add_wb_t2", wb_en, 0);
    idle_cyc(); chk("add_wb_t3", wb_en, 1); chk("add_wbfd_t3", wb_fd, 2);
    idle_cyc(); chk("add_wb_t4", wb_en, 0); chk("add_idle_t4", fpu_idle, 1);

    // MUL fd=3 then dependent ADD: four stall cycles, accepted at T+5
    cyc(1'b0, 1'b1, MUL, 5'd3, 5'd10, 5'd11, 1'b0);
    chk("mul_ready", issue_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, ADD, 5'd12, 5'd3, 5'd13, 1'b0);
      chk("raw_stall", issue_ready, 0);
      chk("raw_nostart", fpu_start, 0);
    end
    cyc(1'b0, 1'b1, ADD, 5'd12, 5'd3, 5'd13, 1'b0);
    chk("raw_accept", issue_ready, 1);
    chk("raw_stall_cnt", stall_cycles, 4);
    for (int i = 0; i < 5; i++) idle_cyc();
    chk("raw_drain_idle", fpu_idle, 1);

    // ADD fd=4 then MOV fd=5 two cycles later: writeback slot conflict
    cyc(1'b0, 1'b1, ADD, 5'd4, 5'd0, 5'd1, 1'b0);
    idle_cyc();
    cyc(1'b0, 1'b1, MOV, 5'd5, 5'd6, 5'd0, 1'b0);
    chk("slot_stall", issue_ready, 0);
    cyc(1'b0, 1'b1, MOV, 5'd5, 5'd6, 5'd0, 1'b0);
    chk("slot_accept", issue_ready, 1);
    chk("slot_add_wb", wb_en, 1);
    chk("slot_add_wbfd", wb_fd, 4);
    cyc(1'b0, 1'b0, MOV, 5'd20, 5'd5, 5'd0, 1'b0);
    chk("slot_mov_wb", wb_en, 1);
    chk("slot_mov_wbfd", wb_fd, 5);
    chk("setclr_busy5", issue_ready, 0);
    #1 issue_fs = 5'd4;
    #1 chk("setclr_free4", issue_ready, 1);
    idle_cyc(); chk("slot_wb_done", wb_en, 0);
    chk("slot_stall_cnt", stall_cycles, 5);

    // Back-to-back DIV: second waits on the divider, accepted at T+12, wb at T+24
    cyc(1'b0, 1'b1, DIV, 5'd6, 5'd0, 5'd1, 1'b0);
    chk("div1_ready", issue_ready, 1);
    for (int i = 1; i <= 11; i++) begin
      cyc(1'b0, 1'b1, DIV, 5'd7, 5'd2, 5'd3, 1'b0);
      chk("div2_stall", issue_ready, 0);
    end
    cyc(1'b0, 1'b1, DIV, 5'd7, 5'd2, 5'd3, 1'b0);
    chk("div2_accept", issue_ready, 1);
    chk("div1_wb", wb_en, 1);
    chk("div1_wbfd", wb_fd, 6);
    chk("div_stall_cnt", stall_cycles, 16);
    for (int i = 13; i <= 23; i++) begin
      idle_cyc();
      chk("div2_no_early_wb", wb_en, 0);
    end
    idle_cyc(); chk("div2_wb", wb_en, 1); chk("div2_wbfd", wb_fd, 7);
    idle_cyc(); chk("div2_idle", fpu_idle, 1);

    // MUL fd=8 flushed at T+2: idle at T+3, no writeback at T+4
    cyc(1'b0, 1'b1, MUL, 5'd8, 5'd0, 5'd1, 1'b0);
    idle_cyc(); chk("flush_busy", fpu_idle, 0);
    cyc(1'b0, 1'b0, ADD, 5'd9, 5'd0, 5'd1, 1'b1);
    chk("flush_ready", issue_ready, 0);
    idle_cyc(); chk("flush_idle", fpu_idle, 1); chk("flush_wb_t3", wb_en, 0);
    idle_cyc(); chk("flush_wb_t4", wb_en, 0);
    chk("flush_stall_cnt", stall_cycles, 16);

    // Illegal op while busy[fs] set
    cyc(1'b0, 1'b1, MUL, 5'd9, 5'd0, 5'd1, 1'b0);
    cyc(1'b0, 1'b1, BAD, 5'd10, 5'd9, 5'd9, 1'b0);
    chk("ill_ready", issue_ready, 1);
    chk("ill_start", fpu_start, 0);
    chk("ill_not_yet", illegal, 0);
    cyc(1'b0, 1'b0, ADD, 5'd11, 5'd9, 5'd1, 1'b0);
    chk("ill_pulse", illegal, 1);
    chk("ill_busy_kept", issue_ready, 0);
    idle_cyc(); chk("ill_pulse_end", illegal, 0);
    idle_cyc(); chk("ill_mul_wb", wb_en, 1); chk("ill_mul_wbfd", wb_fd, 9);
    idle_cyc(); chk("ill_no_extra_wb", wb_en, 0); chk("ill_idle", fpu_idle, 1);

    // Reset mid-operation behaves as a flush
    cyc(1'b0, 1'b1, ADD, 5'd10, 5'd0, 5'd1, 1'b0);
    chk("mid_add_start", fpu_start, 1);
    cyc(1'b1, 1'b1, ADD, 5'd11, 5'd0, 5'd1, 1'b0);
    chk("mid_rst_ready", issue_ready, 0);
    chk("mid_rst_wb", wb_en, 0);
    idle_cyc(); chk("mid_rst_idle", fpu_idle, 1); chk("mid_rst_stall", stall_cycles, 0);
    idle_cyc(); chk("mid_rst_no_wb", wb_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have port cpu_clock, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port cpu_reset_b, input, 1: synchronous reset, active-high.
REQ-003 SHALL have port issue_valid, input, 1: decode presents an FPU instruction.
REQ-004 SHALL have port issue_op, input, 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOV, 101 NEG; 110 and 111 are illegal.
REQ-005 SHALL have ports issue_fd, issue_fs and issue_ft, input, 5 each: destination and source FPR indices.
REQ-006 SHALL have port issue_ready, output, 1: the instruction is accepted this cycle.
REQ-007 SHALL have port flush, input, 1: cancel all in-flight FPU work.
REQ-008 SHALL have port fpu_start, output, 1: launch the FPU datapath this cycle.
REQ-009 SHALL have ports fpu_op (3), fpu_fs (5), fpu_ft (5) and fpu_fd (5), all outputs: the operation and FPR read/write indices for the launched instruction.
REQ-010 SHALL have port wb_en, output, 1: FPR write strobe.
REQ-011 SHALL have port wb_fd, output, 5: FPR write index.
REQ-012 SHALL have port illegal, output, 1: one-cycle pulse when an illegal op is accepted.
REQ-013 SHALL have port fpu_idle, output, 1: no work is in flight.
REQ-014 SHALL have port stall_cycles, output, 16: count of cycles in which issue was stalled.

Function
REQ-015 SHALL use these latencies L: ADD/SUB 3, MUL 4, DIV 12, MOV/NEG 1; an instruction accepted in cycle T has wb_en=1 with wb_fd=fd in cycle T+L.
REQ-016 SHALL keep a 32-bit busy scoreboard; the busy bit of fd is set when the instruction is accepted and cleared in the cycle its wb_en is asserted.
REQ-017 SHALL keep a 12-entry result-slot shift register; entry k holds {valid, fd} for a result due k cycles ahead; all entries shift down by one each cycle; entry 1 drives wb_en and wb_fd.
REQ-018 SHALL keep a 4-bit divider counter: loaded with 12 when a DIV is accepted, decremented to 0; the divider is free only when the counter is 0.
REQ-019 SHALL assert issue_ready for a legal op only when all of the following hold: flush=0; reset is inactive; busy[fs]=0; busy[ft]=0 (ft is ignored for MOV/NEG); busy[fd]=0; the slot due in L cycles is unclaimed after the shift; for DIV only, the divider is free.
REQ-020 SHALL compute issue_ready combinationally from registered state and the issue_* payload, never from issue_valid.
REQ-021 SHALL provide no bypass: a source or destination whose writeback occurs in the current cycle still stalls; issue may proceed the following cycle.
REQ-022 SHALL drive fpu_start = issue_valid & issue_ready & legal op, combinationally, with fpu_op, fpu_fs, fpu_ft and fpu_fd passed through from the issue payload in the same cycle.
REQ-023 SHALL, for an illegal op with flush=0, assert issue_ready=1 regardless of hazards, keep fpu_start=0, leave busy and slot state unchanged, and register illegal=1 for the next cycle only.
REQ-024 SHALL permit setting one busy bit and clearing a different busy bit in the same cycle, with both updates taking effect.
REQ-025 SHALL, when flush=1: hold issue_ready=0 that cycle, take no new issue, and clear all busy bits, all slots and the divider counter at the next edge; a wb_en already asserted in the flush cycle still completes.
REQ-026 SHALL drive fpu_idle=1 exactly when no busy bit is set and the divider counter is 0.
REQ-027 SHALL increment stall_cycles on every cycle with issue_valid=1, issue_ready=0 and reset inactive, saturating at 0xFFFF.

Reset
REQ-028 SHALL, while cpu_reset_b=1 at an edge, clear busy, all slots, the divider counter, illegal and stall_cycles.
REQ-029 SHALL hold issue_ready=0, fpu_start=0 and wb_en=0 throughout the reset cycle.
REQ-030 SHALL, after reset, present wb_en=0, illegal=0, fpu_idle=1 and stall_cycles=0.
REQ-031 SHALL treat a reset arriving mid-operation as an implicit flush, with no later writeback of any in-flight instruction.

Verification
REQ-032 SHALL cover: ADD fd=2, fs=0, ft=1 accepted at T -> fpu_start=1 at T; wb_en=1 with wb_fd=2 at T+3 only; fpu_idle=1 at T+4.
REQ-033 SHALL cover: MUL fd=3 at T, then ADD fs=3 presented at T+1 -> issue_ready=0 for T+1..T+4 with stall_cycles=4; the ADD is accepted at T+5.
REQ-034 SHALL cover: ADD fd=4 at T, then MOV fd=5 at T+2 -> both would write back at T+3, so the MOV stalls at T+2 and is accepted at T+3 with wb at T+4.
REQ-035 SHALL cover: DIV fd=6 at T, then DIV fd=7 at T+1 -> the second DIV stalls until the divider counter reaches 0 and is accepted at T+12; its wb is at T+24.
REQ-036 SHALL cover: MUL fd=8 at T, flush=1 at T+2 -> no wb_en for fd 8 at T+4; fpu_idle=1 at T+3.
REQ-037 SHALL cover: op=111 presented while busy[fs] is set -> issue_ready=1, fpu_start=0, illegal=1 in the next cycle only, scoreboard unchanged.
